// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan path.
// Provides segment/nibble widths, the default scan divider and a blank mask.
package seg_pkg;

    localparam int NIBBLE_W = 4;
    localparam int MAX_DIGITS = 8;

    // All segments off for an active-low 7-segment decoder.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // 50 MHz clock: 50000 cycles per digit gives 1 ms per digit.
    localparam int SCAN_DIV_50MHZ = 50000;

    // Index width for a digit counter, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Bit k (k >= 1) set iff every nibble at positions >= k is zero.
    // Bit 0 is always clear: the least significant digit stays lit.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [MAX_DIGITS*NIBBLE_W-1:0] word,
        input int                             n
    );
        logic [MAX_DIGITS-1:0] m;
        logic                  z;
        m = '0;
        z = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < n) begin
                z    = z & (word[k*NIBBLE_W +: NIBBLE_W] == '0);
                m[k] = z;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Handshake and display bus between a word source and the scan controller.
// master: drives data_in/data_valid/freeze; slave: drives ready and digits.
interface seg_scan_ctrl_if
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic [NUM_DIGITS*NIBBLE_W-1:0] data_in;
    logic                           data_valid;
    logic                           data_ready;
    logic                           freeze;
    logic [NIBBLE_W-1:0]            digit_code;
    logic [NUM_DIGITS-1:0]          digit_sel;
    logic                           digit_blank;
    logic                           frame_tick;

    modport master (
        output data_in,
        output data_valid,
        output freeze,
        input  data_ready,
        input  digit_code,
        input  digit_sel,
        input  digit_blank,
        input  frame_tick
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  freeze,
        output data_ready,
        output digit_code,
        output digit_sel,
        output digit_blank,
        output frame_tick
    );

endinterface

// File: rtl/seg_scan_prescaler.sv
// Digit-rate prescaler and digit index counter for the scan controller.
// Ports: clk, rst, idx_o (current digit), frame_end_o, frame_start_o.
module seg_scan_prescaler
    import seg_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_50MHZ,
    parameter int NUM_DIGITS = 4,
    localparam int PW        = $clog2(SCAN_DIV),
    localparam int IW        = idx_w(NUM_DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx_o,
    output logic          frame_end_o,
    output logic          frame_start_o
);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wrap;
    logic          last_digit;

    assign wrap       = (cnt_q == PW'(SCAN_DIV - 1));
    assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));

    // Both counters wrap by compare so no width ever overflows.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (wrap) begin
            cnt_d = '0;
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o         = idx_q;
    assign frame_end_o   = wrap && last_digit;
    assign frame_start_o = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered hex word to time-multiplexed 7-segment nibble scanner.
// Ports: clk, rst, bus (slave: word handshake in, digit code/select out).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = SCAN_DIV_50MHZ,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_ctrl_if.slave        bus
);

    localparam int W  = NUM_DIGITS * NIBBLE_W;
    localparam int IW = idx_w(NUM_DIGITS);

    logic [IW-1:0]           idx;
    logic                    frame_end;
    logic                    frame_start;

    logic [W-1:0]            pend_q, pend_d;
    logic [W-1:0]            disp_q, disp_d;
    logic                    full_q, full_d;
    logic                    ready_q, ready_d;
    logic [NIBBLE_W-1:0]     code_q, code_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    blank_q, blank_d;
    logic                    tick_q, tick_d;

    logic                    xfer;
    logic                    promote;
    logic [MAX_DIGITS-1:0]   mask;

    seg_scan_prescaler #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_pre (
        .clk           (clk),
        .rst           (rst),
        .idx_o         (idx),
        .frame_end_o   (frame_end),
        .frame_start_o (frame_start)
    );

    assign xfer    = bus.data_valid && ready_q;
    // Never coincides with xfer: ready_q is low whenever full_q is set.
    assign promote = frame_end && full_q && !bus.freeze;
    assign mask    = lz_mask((MAX_DIGITS*NIBBLE_W)'(disp_q), NUM_DIGITS);

    always_comb begin
        pend_d = pend_q;
        disp_d = disp_q;
        full_d = full_q;
        if (xfer) begin
            pend_d = bus.data_in;
            full_d = 1'b1;
        end
        if (promote) begin
            disp_d = pend_q;
            full_d = 1'b0;
        end
        ready_d = !full_d;
    end

    // Outputs follow the current index, so they lag it by one cycle.
    always_comb begin
        code_d  = '0;
        sel_d   = '0;
        blank_d = 1'b0;
        tick_d  = frame_start;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                code_d   = disp_q[k*NIBBLE_W +: NIBBLE_W];
                sel_d[k] = 1'b1;
                blank_d  = LZ_BLANK && mask[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            disp_q  <= '0;
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            code_q  <= '0;
            sel_q   <= NUM_DIGITS'(1);
            blank_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            full_q  <= full_d;
            ready_q <= ready_d;
            code_q  <= code_d;
            sel_q   <= sel_d;
            blank_q <= blank_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.data_ready  = ready_q;
    assign bus.digit_code  = code_q;
    assign bus.digit_sel   = sel_q;
    assign bus.digit_blank = blank_q;
    assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, divider 4).
// Runs an LZ_BLANK=1 and an LZ_BLANK=0 instance on identical stimulus.
module tb_seg_scan_ctrl;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FR  = ND * DIV;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_a ();
    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_b ();

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (DIV),
        .LZ_BLANK   (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (DIV),
        .LZ_BLANK   (1'b0)
    ) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset, pending slot and shown word.
    int          n;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_full;
    bit          m_xfer;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h",
                   tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_disp = '0;
        m_pend = '0;
        m_full = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [15:0] d, input bit fz);
        bus_a.data_valid = v;
        bus_a.data_in    = d;
        bus_a.freeze     = fz;
        bus_b.data_valid = v;
        bus_b.data_in    = d;
        bus_b.freeze     = fz;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"},   32'(bus_a.digit_sel),   32'h1);
        chk({tag, "_code"},  32'(bus_a.digit_code),  32'h0);
        chk({tag, "_blank"}, 32'(bus_a.digit_blank), 32'h0);
        chk({tag, "_tick"},  32'(bus_a.frame_tick),  32'h0);
        chk({tag, "_ready"}, 32'(bus_a.data_ready),  32'h1);
        chk({tag, "_nbsel"}, 32'(bus_b.digit_sel),   32'h1);
    endtask

    // One clock: apply inputs, advance the model, check both instances.
    task automatic step(input bit v, input logic [15:0] d, input bit fz);
        int          e_idx;
        logic [15:0] old_disp;
        logic [3:0]  e_code;
        bit          e_blank;
        bit          e_tick;
        drive(v, d, fz);
        // Outputs after this edge reflect the digit in force before it.
        e_idx    = (n / DIV) % ND;
        e_tick   = (n % FR) == 0;
        old_disp = m_disp;
        e_code   = 4'((old_disp >> (4 * e_idx)) & 16'hF);
        e_blank  = (e_idx != 0) && ((old_disp >> (4 * e_idx)) == 16'h0);
        m_xfer   = v && !m_full;
        if (((n + 1) % FR) == 0 && m_full && !fz) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (m_xfer) begin
            m_pend = d;
            m_full = 1'b1;
        end
        @(posedge clk);
        #1;
        n++;
        chk("sel",    32'(bus_a.digit_sel),   32'(1 << e_idx));
        chk("code",   32'(bus_a.digit_code),  32'(e_code));
        chk("blank",  32'(bus_a.digit_blank), 32'(e_blank));
        chk("tick",   32'(bus_a.frame_tick),  32'(e_tick));
        chk("ready",  32'(bus_a.data_ready),  32'(!m_full));
        chk("nbcode", 32'(bus_b.digit_code),  32'(e_code));
        chk("nbblank", 32'(bus_b.digit_blank), 32'h0);
    endtask

    task automatic idle(input int cyc, input bit fz);
        for (int i = 0; i < cyc; i++) step(1'b0, 16'h0, fz);
    endtask

    // Hold valid until accepted, bounded by a cycle budget.
    task automatic send(input logic [15:0] d, input bit fz);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4 * FR && !done; i++) begin
            step(1'b1, d, fz);
            done = m_xfer;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout observed=none expected=%h", d);
        end
    endtask

    initial begin
        logic [15:0] rd;
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0);
        model_reset();
        #2;
        chk_reset("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run from reset: zeros, digits 1..3 blanked.
        idle(32, 1'b0);

        // Single word offered mid-frame.
        idle(5, 1'b0);
        send(16'hA5C3, 1'b0);
        idle(2 * FR, 1'b0);

        // Back-to-back offers with valid held high.
        send(16'h1234, 1'b0);
        send(16'h5678, 1'b0);
        idle(2 * FR, 1'b0);

        // Freeze blocks promotion for three frames.
        send(16'h00F0, 1'b1);
        idle(3 * FR, 1'b1);
        idle(2 * FR, 1'b0);

        // Async reset mid-digit with a word pending.
        idle(3, 1'b0);
        send(16'hBEEF, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_reset("rst1");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        idle(2 * FR, 1'b0);

        // Small value: leading-zero blanking versus never-blank instance.
        send(16'h0007, 1'b0);
        idle(2 * FR, 1'b0);

        // Randomised traffic with occasional freeze.
        for (int i = 0; i < 300; i++) begin
            rd = 16'($urandom) >> $urandom_range(0, 15);
            step($urandom_range(0, 3) == 0, rd, $urandom_range(0, 7) == 0);
        end
        idle(2 * FR, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
